// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//  - 4-bit opcodes, also imported by the CPU control unit.
//  - Sequencer state encoding for alu_seq_unit.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_SRA  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// ALU request/response bundle.
//  master (CPU side): drives start, op, a, b; receives busy, done, result,
//                     result_hi, zero, overflow, div_by_zero.
//  slave  (ALU side): the mirror image.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, zero, overflow, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, zero, overflow, div_by_zero
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per step.
//  clk, rst  : clock, synchronous active-high reset
//  load_i    : capture operands and clear the bit counter
//  is_div_i  : with load_i, selects divide (1) or multiply (0)
//  step_i    : advance one bit
//  a_i, b_i  : operands captured on load_i
//  hi_o/lo_o : accumulator value after the current step (product hi/lo,
//              or remainder/quotient); valid as the final answer when last_o
//  last_o    : the current step is the final (WIDTH-th) one
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             last_o
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, m_q;
    logic             div_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum, shl, diff;

    // Multiply: lo holds the multiplier and shifts right as product bits
    // arrive from the top. Divide: lo holds the dividend and shifts left
    // while quotient bits enter at the bottom; hi is the partial remainder.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, m_q};
        if (div_q) begin
            if (shl >= {1'b0, m_q}) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shl[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= is_div_i ? a_i : b_i;
            m_q   <= is_div_i ? b_i : a_i;
            div_q <= is_div_i;
        end else if (step_i) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi_o   = hi_d;
    assign lo_o   = lo_d;
    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/alu_seq_unit.sv
// EX-stage ALU with start/busy/done handshake.
//  clk, rst : clock, synchronous active-high reset
//  bus      : slave side of alu_seq_unit_if (start/op/a/b in; busy, done,
//             result, result_hi, zero, overflow, div_by_zero out)
// Single-cycle ops finish one cycle after start; MULU/DIVU run WIDTH
// iterations in muldiv_iter. All response outputs are registered.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic           clk,
    input logic           rst,
    alu_seq_unit_if.slave bus
);
    state_t state_q, state_d;

    logic [WIDTH-1:0]        alu_res, sum, diff;
    logic                    alu_ovf;
    logic [SHAMT_W-1:0]      shamt;
    logic signed [WIDTH-1:0] a_s, b_s;

    logic             md_load, md_div, md_step, md_last;
    logic [WIDTH-1:0] md_hi, md_lo;

    logic             wr;
    logic [WIDTH-1:0] res_d, hi_d;
    logic             ovf_d, dbz_d;
    logic [WIDTH-1:0] result_q, hi_q;
    logic             done_q, zero_q, ovf_q, dbz_q;

    // Single-cycle datapath
    always_comb begin
        a_s     = bus.a;
        b_s     = bus.b;
        shamt   = bus.b[SHAMT_W-1:0];
        sum     = bus.a + bus.b;
        diff    = bus.a - bus.b;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLL:  alu_res = bus.a << shamt;
            OP_SRL:  alu_res = bus.a >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            default: alu_res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load_i   (md_load),
        .is_div_i (md_div),
        .step_i   (md_step),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .hi_o     (md_hi),
        .lo_o     (md_lo),
        .last_o   (md_last)
    );

    // FIN is the done cycle of a MULU/DIVU; busy is already low there, so
    // a new start is dispatched exactly as from IDLE.
    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        md_div  = 1'b0;
        md_step = 1'b0;
        wr      = 1'b0;
        res_d   = '0;
        hi_d    = '0;
        ovf_d   = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    if (bus.op == OP_MULU) begin
                        md_load = 1'b1;
                        state_d = ST_MUL;
                    end else if (bus.op == OP_DIVU) begin
                        if (bus.b != '0) begin
                            md_load = 1'b1;
                            md_div  = 1'b1;
                            state_d = ST_DIV;
                        end else begin
                            wr    = 1'b1;
                            res_d = '1;
                            hi_d  = bus.a;
                            dbz_d = 1'b1;
                        end
                    end else begin
                        wr    = 1'b1;
                        res_d = alu_res;
                        ovf_d = alu_ovf;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                md_step = 1'b1;
                if (md_last) begin
                    wr      = 1'b1;
                    res_d   = md_lo;
                    hi_d    = md_hi;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= wr;
            if (wr) begin
                result_q <= res_d;
                hi_q     <= hi_d;
                zero_q   <= (res_d == '0);
                ovf_q    <= ovf_d;
                dbz_q    <= dbz_d;
            end
        end
    end

    assign bus.busy        = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_hi   = hi_q;
    assign bus.zero        = zero_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: a WIDTH=32 and a WIDTH=16 instance share one
// clock/reset; w16 selects which instance is driven and observed.
module tb_alu_seq_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w16 = 1'b0;
    logic        start_r = 1'b0;
    logic [3:0]  op_r = 4'd0;
    logic [31:0] a_r = '0;
    logic [31:0] b_r = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(32)) bus32 ();
    alu_seq_unit_if #(.WIDTH(16)) bus16 ();

    alu_seq_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    alu_seq_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    assign bus32.start = start_r && !w16;
    assign bus32.op    = op_r;
    assign bus32.a     = a_r;
    assign bus32.b     = b_r;
    assign bus16.start = start_r && w16;
    assign bus16.op    = op_r;
    assign bus16.a     = a_r[15:0];
    assign bus16.b     = b_r[15:0];

    logic        done_s, busy_s, zero_s, ovf_s, dbz_s;
    logic [31:0] res_s, hi_s;
    assign done_s = w16 ? bus16.done        : bus32.done;
    assign busy_s = w16 ? bus16.busy        : bus32.busy;
    assign zero_s = w16 ? bus16.zero        : bus32.zero;
    assign ovf_s  = w16 ? bus16.overflow    : bus32.overflow;
    assign dbz_s  = w16 ? bus16.div_by_zero : bus32.div_by_zero;
    assign res_s  = w16 ? {16'h0, bus16.result}    : bus32.result;
    assign hi_s   = w16 ? {16'h0, bus16.result_hi} : bus32.result_hi;

    typedef struct {
        logic        w16;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one start pulse; returns at #1 after the edge that samples it.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_r = 1'b1;
        op_r    = op;
        a_r     = a;
        b_r     = b;
        @(posedge clk);
        #1;
        start_r = 1'b0;
    endtask

    // c = number of cycles after the start edge at which done was seen.
    task automatic wait_done(input int lim, output int c);
        c = 1;
        while (done_s !== 1'b1 && c < lim) begin
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic reset_check(input string nm);
        chk({nm, " busy"},  32'(busy_s), 32'd0);
        chk({nm, " done"},  32'(done_s), 32'd0);
        chk({nm, " res"},   res_s,       32'd0);
        chk({nm, " hi"},    hi_s,        32'd0);
        chk({nm, " zero"},  32'(zero_s), 32'd1);
        chk({nm, " ovf"},   32'(ovf_s),  32'd0);
        chk({nm, " dbz"},   32'(dbz_s),  32'd0);
    endtask

    initial begin
        int  c;
        logic b1, b32, saw;

        // WIDTH=32 vectors
        vt.push_back('{1'b0, OP_ADD,  32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b0, OP_SUB,  32'd5,         32'd5,        32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_SUB,  32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b0, OP_SLT,  32'hFFFF_FFFF, 32'd1,        32'd1,         32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_SRA,  32'hF000_0000, 32'd4,        32'hFF00_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_SRL,  32'hF000_0000, 32'd4,        32'h0F00_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_SLL,  32'd1,         32'h25,       32'd32,        32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_NOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, 4'd13,   32'd5,         32'd5,        32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{1'b0, OP_MULU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0, 33});
        vt.push_back('{1'b0, OP_DIVU, 32'd100,       32'd7,        32'd14,        32'd2, 1'b0, 1'b0, 1'b0, 33});
        vt.push_back('{1'b0, OP_DIVU, 32'd9,         32'd0,        32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, 1});
        vt.push_back('{1'b0, OP_ADD,  32'd1,         32'd1,        32'd2,         32'd0, 1'b0, 1'b0, 1'b0, 1});
        // WIDTH=16 vectors
        vt.push_back('{1'b1, OP_ADD,  32'h7FFF,      32'd1,        32'h8000,      32'd0, 1'b0, 1'b1, 1'b0, 1});
        vt.push_back('{1'b1, OP_SUB,  32'd5,         32'd5,        32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_SLT,  32'hFFFF,      32'd1,        32'd1,         32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_SLTU, 32'hFFFF,      32'd1,        32'd0,         32'd0, 1'b1, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_SRA,  32'hF000,      32'd4,        32'hFF00,      32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_SRL,  32'hF000,      32'd4,        32'h0F00,      32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_SLL,  32'd1,         32'h25,       32'd32,        32'd0, 1'b0, 1'b0, 1'b0, 1});
        vt.push_back('{1'b1, OP_MULU, 32'hFFFF,      32'd2,        32'hFFFE,      32'd1, 1'b0, 1'b0, 1'b0, 17});
        vt.push_back('{1'b1, OP_DIVU, 32'd100,       32'd7,        32'd14,        32'd2, 1'b0, 1'b0, 1'b0, 17});
        vt.push_back('{1'b1, OP_DIVU, 32'd9,         32'd0,        32'hFFFF,      32'd9, 1'b0, 1'b0, 1'b1, 1});

        repeat (3) @(posedge clk);
        #1;
        w16 = 1'b0;
        #1;
        reset_check("rst32");
        w16 = 1'b1;
        #1;
        reset_check("rst16");
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) begin
            w16 = vt[i].w16;
            launch(vt[i].op, vt[i].a, vt[i].b);
            wait_done(vt[i].lat + 4, c);
            chk($sformatf("v%0d lat", i),  32'(c),      32'(vt[i].lat));
            chk($sformatf("v%0d res", i),  res_s,       vt[i].res);
            chk($sformatf("v%0d hi", i),   hi_s,        vt[i].hi);
            chk($sformatf("v%0d zero", i), 32'(zero_s), 32'(vt[i].z));
            chk($sformatf("v%0d ovf", i),  32'(ovf_s),  32'(vt[i].ovf));
            chk($sformatf("v%0d dbz", i),  32'(dbz_s),  32'(vt[i].dbz));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pulse", i), 32'(done_s), 32'd0);
        end

        // Start pulse while busy must not disturb the running MULU.
        w16 = 1'b0;
        launch(OP_MULU, 32'hFFFF_FFFF, 32'd2);
        c   = 1;
        b1  = busy_s;
        b32 = 1'b0;
        while (done_s !== 1'b1 && c < 40) begin
            if (c == 5) begin
                @(negedge clk);
                start_r = 1'b1;
                op_r    = OP_ADD;
                a_r     = 32'd3;
                b_r     = 32'd4;
            end
            @(posedge clk);
            #1;
            start_r = 1'b0;
            c++;
            if (c == 32) b32 = busy_s;
        end
        chk("ign lat",     32'(c),      32'd33);
        chk("ign busy1",   32'(b1),     32'd1);
        chk("ign busy32",  32'(b32),    32'd1);
        chk("ign busydn",  32'(busy_s), 32'd0);
        chk("ign res",     res_s,       32'hFFFF_FFFE);
        chk("ign hi",      hi_s,        32'd1);

        // Reset in the middle of a MULU: no done, outputs back to reset values.
        launch(OP_MULU, 32'd7, 32'd6);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("abort busy", 32'(busy_s), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        reset_check("abort");
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_s === 1'b1) saw = 1'b1;
        end
        chk("abort nodone", 32'(saw), 32'd0);

        // Start in the done cycle of a MULU is accepted.
        launch(OP_MULU, 32'd3, 32'd5);
        wait_done(40, c);
        chk("b2b lat", 32'(c), 32'd33);
        chk("b2b mul", res_s,  32'd15);
        launch(OP_ADD, 32'd2, 32'd3);
        chk("b2b done", 32'(done_s), 32'd1);
        chk("b2b add",  res_s,       32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
